// File: rtl/cascaded_prescaler.sv
// N-stage programmable prescaler on a single clock with per-stage enables and a handshaked divisor reload.
// Define PRESC_SNAPSHOT_EN to expose the live counters (CNT_OUT) and active divisors (DIV_OUT).
module cascaded_prescaler #(
  parameter int STAGES  = 2,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      CLR,
  input  logic [STAGES*DIV_W-1:0]   DIV_IN,
  input  logic                      LOAD,
  output logic                      PENDING,
  output logic                      LOAD_ACK,
  output logic [STAGES-1:0]         STAGE_TICK,
  output logic                      TICK,
  output logic                      OUT_CLK
`ifdef PRESC_SNAPSHOT_EN
  ,
  output logic [STAGES*DIV_W-1:0]   CNT_OUT,
  output logic [STAGES*DIV_W-1:0]   DIV_OUT
`endif
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RST);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                          state_q;
  logic [STAGES-1:0][DIV_W-1:0]    cnt_q;
  logic [STAGES-1:0][DIV_W-1:0]    div_q;
  logic [STAGES-1:0][DIV_W-1:0]    shadow_q;
  logic [STAGES-1:0]               adv;
  logic [STAGES-1:0]               term;
  logic                            run;
  logic                            all_zero;
  logic                            apply;

  // The advance ripples through the chain: a stage advances only when every earlier stage is terminal.
  always_comb begin
    run      = EN & ~CLR;
    all_zero = 1'b1;
    adv      = '0;
    term     = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s]   = run;
      run      = run & (cnt_q[s] == div_q[s]);
      term[s]  = run;
      all_zero = all_zero & (cnt_q[s] == '0);
    end
  end

  assign apply = (state_q == PEND) & (term[STAGES-1] | (~EN & all_zero) | CLR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q      <= '0;
      STAGE_TICK <= '0;
      TICK       <= 1'b0;
      OUT_CLK    <= 1'b0;
    end else if (CLR) begin
      cnt_q      <= '0;
      STAGE_TICK <= '0;
      TICK       <= 1'b0;
      OUT_CLK    <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          cnt_q[s] <= term[s] ? '0 : cnt_q[s] + DIV_W'(1);
        end
      end
      STAGE_TICK <= term;
      TICK       <= term[STAGES-1];
      OUT_CLK    <= OUT_CLK ^ term[STAGES-1];
    end
  end

  // Divisors are swapped only where every counter is at 0, so the ratio never changes mid-period.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shadow_q <= {STAGES{RST_DIV}};
      div_q    <= {STAGES{RST_DIV}};
      PENDING  <= 1'b0;
      LOAD_ACK <= 1'b0;
    end else begin
      LOAD_ACK <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LOAD) begin
            shadow_q <= DIV_IN;
            PENDING  <= 1'b1;
            state_q  <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            div_q    <= shadow_q;
            LOAD_ACK <= 1'b1;
            PENDING  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PRESC_SNAPSHOT_EN
  assign CNT_OUT = cnt_q;
  assign DIV_OUT = div_q;
`endif

endmodule

// File: tb/tb_cascaded_prescaler.sv
// Directed bench for cascaded_prescaler with STAGES=2, DIV_W=4: vector table plus hand-written reload sequences.
module tb_cascaded_prescaler;

  localparam int STAGES = 2;
  localparam int DIV_W  = 4;

  typedef struct packed {
    logic [1:0] stick;
    logic       tick;
    logic       oclk;
    logic       pend;
    logic       ack;
  } outs_t;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] div;
    outs_t      exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        CLR = 1'b0;
  logic        LOAD = 1'b0;
  logic [7:0]  DIV_IN = '0;
  logic        PENDING;
  logic        LOAD_ACK;
  logic [1:0]  STAGE_TICK;
  logic        TICK;
  logic        OUT_CLK;
`ifdef PRESC_SNAPSHOT_EN
  logic [7:0]  CNT_OUT;
  logic [7:0]  DIV_OUT;
`endif

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl [15];

  cascaded_prescaler #(.STAGES(STAGES), .DIV_W(DIV_W), .DIV_RST(0)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .DIV_IN(DIV_IN), .LOAD(LOAD),
    .PENDING(PENDING), .LOAD_ACK(LOAD_ACK), .STAGE_TICK(STAGE_TICK),
    .TICK(TICK), .OUT_CLK(OUT_CLK)
`ifdef PRESC_SNAPSHOT_EN
    , .CNT_OUT(CNT_OUT), .DIV_OUT(DIV_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic en, input logic clr, input logic load, input logic [7:0] div);
    @(negedge CLK);
    EN     = en;
    CLR    = clr;
    LOAD   = load;
    DIV_IN = div;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t got;
    got = '{stick: STAGE_TICK, tick: TICK, oclk: OUT_CLK, pend: PENDING, ack: LOAD_ACK};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got stick=%b tick=%b oclk=%b pend=%b ack=%b, want stick=%b tick=%b oclk=%b pend=%b ack=%b",
               name, got.stick, got.tick, got.oclk, got.pend, got.ack,
               exp.stick, exp.tick, exp.oclk, exp.pend, exp.ack);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Run with EN=1 until TICK, returning the cycle count (0 on timeout) and stage-0 strobes seen.
  task automatic runToTick(input int bound, output int cycles, output int s0_ticks);
    bit hit;
    hit = 1'b0;
    cycles = 0;
    s0_ticks = 0;
    for (int i = 1; i <= bound && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      if (STAGE_TICK[0]) s0_ticks++;
      if (TICK) begin
        hit = 1'b1;
        cycles = i;
      end
    end
  endtask

  initial begin
    int n;
    int s0;

    // Idle load of (s0=2, s1=1), then two full TICK periods of six cycles.
    tbl[0]  = '{en:0, clr:0, load:1, div:8'h12, exp:'{2'b00, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{en:0, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[2]  = '{en:0, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b01, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b11, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[10] = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b01, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[12] = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[13] = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b00, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[14] = '{en:1, clr:0, load:0, div:8'h00, exp:'{2'b11, 1'b1, 1'b0, 1'b0, 1'b0}};

    #12;
    checkOutput("reset_state", '0);
    @(negedge CLK);
    RST = 1'b1;

    // With DIV_RST=0 the first enabled cycle is a full-cascade terminal.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("first_tick", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
    #2;
    RST = 1'b0;
    EN  = 1'b0;
    #1;
    checkOutput("async_reset", '0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].div);
      checkOutput($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Mid-run reload of (0,0) with stage 0 at count 2; a second LOAD of (15,15) must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reload_c0", '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reload_c1", '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("reload_req", '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
    checkOutput("reload_ignored", '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reload_wait", '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reload_apply", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("div1_a", '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("div1_b", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("div1_c", '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0});

    // Fresh LOAD of (15,15) applies at the very next terminal, giving a 256-cycle period.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
    checkOutput("max_req", '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("max_apply", '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1});
    runToTick(300, n, s0);
    checkValue("max_period", n, 256);
    checkValue("max_stage0_ticks", s0, 16);
    checkOutput("max_tick", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0});

    // Back to (2,1) via an idle load, then a 5-cycle EN gap mid-period.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h12);
    checkOutput("idle_req", '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_apply", '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("gap_pre%0d", i), '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("gap_hold%0d", i), '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    runToTick(20, n, s0);
    checkValue("gap_remaining", n, 4);
    checkOutput("gap_tick", '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0});

    // One more period to raise OUT_CLK, then CLR lands on the final-stage terminal with a load pending.
    runToTick(20, n, s0);
    checkValue("period6", n, 6);
    checkOutput("period6_tick", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("clr_c0", '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_c1", '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_c2", '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_c3", '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_c4", '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("clr_collide", '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_restart", '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cascaded_prescaler.md
Name: cascaded_prescaler

Overview:
- Parametrised N-stage programmable prescaler; successor to the two-stage clock divider.
- All stages run in the single CLK domain. Each stage advances on a clock enable from the stage before it; no derived clocks drive later stages.
- Adds per-stage tick strobes, an enable input, synchronous clear, and a handshaked divisor reload. A new divisor takes effect only at a full-cascade wrap, so OUT_CLK never glitches.
- Sits between the system clock and slow peripherals (LED scan, UART baud, debounce sampling).

Parameters:
STAGES, 2, number of cascaded divider stages (>=1)
DIV_W, 8, width of each stage's counter and divisor
DIV_RST, 0, reset value of every active divisor (0 = divide by 1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset (0 = reset asserted)
EN  in  1  count enable for stage 0
CLR  in  1  synchronous clear of counters and outputs
DIV_IN  in  STAGES*DIV_W  requested divisors; stage s uses bits [s*DIV_W +: DIV_W]
LOAD  in  1  divisor load request, sampled each cycle
PENDING  out  1  a latched divisor set is waiting to be applied
LOAD_ACK  out  1  one-cycle pulse when pending divisors become active
STAGE_TICK  out  STAGES  registered one-cycle terminal strobe per stage
TICK  out  1  registered one-cycle strobe from the final stage
OUT_CLK  out  1  toggles on every final-stage terminal

Behaviour:
- Reset (RST=0, asynchronous, at any time including mid-count):
  - counters = 0; active divisors = DIV_RST; shadow divisors = DIV_RST.
  - PENDING, LOAD_ACK, STAGE_TICK, TICK and OUT_CLK = 0.
- Advance: adv_0 = EN & ~CLR; adv_s = term_(s-1) for s > 0.
- Terminal: term_s = adv_s & (cnt_s == div_s). Terminal and advance are combinational inside the block.
- On adv_s: if term_s then cnt_s <= 0, else cnt_s <= cnt_s + 1. If adv_s is 0, cnt_s holds.
- Stage ratio is div_s+1. TICK period = product of (div_s+1) cycles at EN=1; OUT_CLK period = 2x that.
- div_s = 0: stage passes every advance through. div_s = 2^DIV_W-1: stage counts the full range with no overflow past the terminal.
- Outputs are registered, 1 cycle after the terminal cycle:
  - STAGE_TICK[s] <= term_s
  - TICK <= term_(STAGES-1)
  - OUT_CLK <= OUT_CLK ^ term_(STAGES-1)
- CLR=1:
  - counters <= 0; STAGE_TICK, TICK and OUT_CLK <= 0.
  - PENDING, shadow and active divisors are unchanged.
  - CLR overrides a terminal in the same cycle: no tick is produced.
- Load FSM, two states:
  - IDLE: LOAD=1 -> shadow <= DIV_IN, PENDING <= 1, go to PEND.
  - PEND: apply when term_(STAGES-1)=1, or when EN=0 and all counters are 0, or when CLR=1.
  - Apply: active <= shadow, LOAD_ACK <= 1 for one cycle, PENDING <= 0, go to IDLE.
  - LOAD while in PEND is ignored; the shadow is not overwritten.
  - LOAD in the same cycle as apply is ignored.
- Apply at terminal: all counters wrap to 0 in that cycle, so the new divisors govern counting from the next cycle. The current final period completes with the old ratio.
- EN low holds all counters. The tick phase shifts by the number of held cycles.

Optional Feature:
- Macro: PRESC_SNAPSHOT_EN.
- Defined: adds two ports.
  - CNT_OUT, out, STAGES*DIV_W: live counter values, combinational from the counter registers.
  - DIV_OUT, out, STAGES*DIV_W: currently active divisors.
- Not defined: both ports and their logic are absent.
- Core behaviour is identical either way.

Test Plan:
Test configuration is STAGES=2, DIV_W=4.
1. Reset: RST=0 asserted mid-count with OUT_CLK=1 -> all outputs 0 immediately without a clock edge. After release, the first TICK arrives after 1 cycle of EN with DIV_RST=0.
2. Idle load: EN=0, LOAD with divisors s0=2, s1=1 -> LOAD_ACK on the next cycle, PENDING is 1 for one cycle. Then EN=1 -> STAGE_TICK[0] every 3 cycles, TICK every 6 cycles, OUT_CLK high 6 / low 6.
3. Mid-run reload: running with (2,1), LOAD with (0,0) at count 2 -> PENDING stays 1 until the next TICK and LOAD_ACK coincides with it. Afterwards TICK fires every cycle and OUT_CLK toggles every cycle.
4. Ignored reload: second LOAD with (15,15) while PENDING -> shadow keeps (0,0). After apply, a fresh LOAD with (15,15) gives TICK every 256 cycles.
5. Enable gating: running with (2,1), EN=0 for 5 cycles mid-period -> counters frozen, no ticks. The next TICK arrives 5 cycles later than it would have without the gap.
6. Clear collision: CLR=1 in the cycle the final stage hits terminal -> no TICK and OUT_CLK = 0. The pending load is applied with LOAD_ACK, and counting restarts from 0.
